// File: rtl/nios_qsys_pio_in_irq_if.sv
// Avalon-MM slave bus bundle for the input PIO.
// It carries the address, chip select, write strobe, write data and read data.
interface nios_qsys_pio_in_irq_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/nios_qsys_pio_in_irq.sv
// Avalon-MM input PIO: per-bit sync, optional debounce, edge capture (W1C) and maskable level IRQ.
// Optional feature: define PIO_IN_DEBOUNCE_EN to enable per-bit debounce filtering.
module nios_qsys_pio_in_irq_lane #(
  parameter int EDGE_TYPE       = 0,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic filt,
  output logic hit
);
  logic s1, s2, filt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      filt_d <= 1'b0;
    end else begin
      s1     <= pin;
      s2     <= s1;
      filt_d <= filt;
    end
  end

`ifdef PIO_IN_DEBOUNCE_EN
  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  logic [CW-1:0] cnt;

  // filt follows s2 only after DEBOUNCE_CYCLES consecutive mismatching cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      filt <= 1'b0;
    end else if (s2 == filt) begin
      cnt  <= '0;
    end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
      cnt  <= '0;
      filt <= s2;
    end else begin
      cnt  <= cnt + 1'b1;
    end
  end
`else
  assign filt = s2;
`endif

  generate
    if (EDGE_TYPE == 0) begin : g_rise
      assign hit = filt & ~filt_d;
    end else if (EDGE_TYPE == 1) begin : g_fall
      assign hit = ~filt & filt_d;
    end else begin : g_any
      assign hit = filt ^ filt_d;
    end
  endgenerate
endmodule

module nios_qsys_pio_in_irq #(
  parameter int WIDTH           = 8,
  parameter int EDGE_TYPE       = 0,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  nios_qsys_pio_in_irq_if.slave   bus,
  input  logic [WIDTH-1:0]        in_port,
  output logic                    irq
);
  logic [WIDTH-1:0] filt, hit, mask, edgecap, clr, wdata;
  logic             wr;

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_lane
      nios_qsys_pio_in_irq_lane #(
        .EDGE_TYPE       (EDGE_TYPE),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_lane (
        .clk   (clk),
        .reset (reset),
        .pin   (in_port[i]),
        .filt  (filt[i]),
        .hit   (hit[i])
      );
    end
  endgenerate

  assign wr    = bus.chipselect & ~bus.write_n;
  assign wdata = bus.writedata[WIDTH-1:0];
  assign clr   = (wr && bus.address == 2'd2) ? wdata : '0;

  // OR-ing hit after the clear lets a same-cycle edge survive a W1C write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask         <= '0;
      edgecap      <= '0;
      irq          <= 1'b0;
      bus.readdata <= '0;
    end else begin
      if (wr && bus.address == 2'd1) mask <= wdata;
      edgecap <= (edgecap & ~clr) | hit;
      irq     <= |(edgecap & mask);
      case (bus.address)
        2'd0:    bus.readdata <= 32'(filt);
        2'd1:    bus.readdata <= 32'(mask);
        2'd2:    bus.readdata <= 32'(edgecap);
        default: bus.readdata <= '0;
      endcase
    end
  end
endmodule
